// File: rtl/y_gauss_3x3.sv
// rtl/y_gauss_3x3.sv - streaming 3x3 Gaussian smoothing of luma with aligned sync/de
// Two line buffers plus a 3x3 window; three register stages give a fixed 3-cycle latency.
module y_gauss_3x3 #(
  parameter int H_ACTIVE = 800,
  parameter int DW       = 8,
  parameter int SYNC_POL = 0
) (
  input  logic          pixel_clk,
  input  logic          reset_n,
  input  logic [DW-1:0] i_y,
  input  logic          i_h_sync,
  input  logic          i_v_sync,
  input  logic          i_de,
  output logic [DW-1:0] o_y,
  output logic          o_h_sync,
  output logic          o_v_sync,
  output logic          o_de
);

  localparam int CW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int SW = DW + 4;
  localparam logic [CW-1:0] COL_MAX = CW'(H_ACTIVE - 1);

  logic [CW-1:0] col;
  logic          ovf;
  logic [11:0]   row;
  logic          de_d;
  logic          wr_en;

  logic [DW-1:0] lb0 [H_ACTIVE];
  logic [DW-1:0] lb1 [H_ACTIVE];
  logic [DW-1:0] tap_top;
  logic [DW-1:0] tap_mid;

  logic [DW-1:0] win [3][3];
  logic          valid_win;
  logic [SW-1:0] s_top, s_mid, s_bot;
  logic          valid_sum;
  logic [SW-1:0] sum;
  logic [2:0]    hs_p, vs_p, de_p;

  assign wr_en   = i_de && !ovf;
  assign tap_top = lb1[col];
  assign tap_mid = lb0[col];

  // ovf marks pixels past the last buffer column; col itself stays saturated.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      col  <= '0;
      ovf  <= 1'b0;
      row  <= '0;
      de_d <= 1'b0;
    end else begin
      de_d <= i_de;
      if (i_de) begin
        if (col == COL_MAX) ovf <= 1'b1;
        else                col <= col + CW'(1);
      end else begin
        col <= '0;
        ovf <= 1'b0;
      end
      if (i_v_sync == 1'(SYNC_POL))
        row <= '0;
      else if (de_d && !i_de && row != 12'hfff)
        row <= row + 12'd1;
    end
  end

  // Read-before-write: lb1 takes the previous line's value out of lb0.
  always_ff @(posedge pixel_clk) begin
    if (wr_en) begin
      lb0[col] <= i_y;
      lb1[col] <= lb0[col];
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
      valid_win <= 1'b0;
    end else begin
      if (i_de) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= tap_top;
        win[1][2] <= tap_mid;
        win[2][2] <= i_y;
      end
      valid_win <= i_de && (row >= 12'd2) && (int'(col) >= 2) && !ovf;
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      s_top     <= '0;
      s_mid     <= '0;
      s_bot     <= '0;
      valid_sum <= 1'b0;
    end else begin
      s_top     <= SW'(win[0][0]) + (SW'(win[0][1]) << 1) + SW'(win[0][2]);
      s_mid     <= (SW'(win[1][0]) + (SW'(win[1][1]) << 1) + SW'(win[1][2])) << 1;
      s_bot     <= SW'(win[2][0]) + (SW'(win[2][1]) << 1) + SW'(win[2][2]);
      valid_sum <= valid_win;
    end
  end

  assign sum = s_top + s_mid + s_bot;

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_p <= '0;
      vs_p <= '0;
      de_p <= '0;
      o_y  <= '0;
    end else begin
      hs_p <= {hs_p[1:0], i_h_sync};
      vs_p <= {vs_p[1:0], i_v_sync};
      de_p <= {de_p[1:0], i_de};
      o_y  <= (valid_sum && de_p[1]) ? DW'(sum >> 4) : '0;
    end
  end

  assign o_h_sync = hs_p[2];
  assign o_v_sync = vs_p[2];
  assign o_de     = de_p[2];

endmodule

// File: tb/tb_y_gauss_3x3.sv
// tb/tb_y_gauss_3x3.sv - self-checking bench for y_gauss_3x3 against an image-array model
module tb_y_gauss_3x3;
  localparam int H = 16;

  logic       pixel_clk = 1'b0;
  logic       reset_n   = 1'b0;
  logic [7:0] i_y       = '0;
  logic       i_h_sync  = 1'b0;
  logic       i_v_sync  = 1'b0;
  logic       i_de      = 1'b0;
  logic [7:0] o_y;
  logic       o_h_sync;
  logic       o_v_sync;
  logic       o_de;

  y_gauss_3x3 #(.H_ACTIVE(H), .DW(8), .SYNC_POL(0)) dut (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .i_y       (i_y),
    .i_h_sync  (i_h_sync),
    .i_v_sync  (i_v_sync),
    .i_de      (i_de),
    .o_y       (o_y),
    .o_h_sync  (o_h_sync),
    .o_v_sync  (o_v_sync),
    .o_de      (o_de)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    int y;
    bit hs;
    bit vs;
    bit de;
    int r;
    int c;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  int   img[64][32];
  int   obs_img[64][32];
  int   m_row = 0;
  int   m_col = 0;
  bit   m_prev_de = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic prefill();
    exp_t z;
    z = '{default: 0};
    q.delete();
    repeat (3) q.push_back(z);
  endtask

  // Reference: store the frame as an image and apply the kernel centred one row/col back.
  task automatic step(input int y, input bit hs, input bit vs, input bit de);
    exp_t e, o;
    int   sum, wt;
    @(negedge pixel_clk);
    o = q.pop_front();
    chk("o_y", o_y, o.y);
    chk("o_h_sync", o_h_sync, o.hs);
    chk("o_v_sync", o_v_sync, o.vs);
    chk("o_de", o_de, o.de);
    if (o.de && o.r < 64 && o.c < 32) obs_img[o.r][o.c] = int'(o_y);
    i_y = 8'(y); i_h_sync = hs; i_v_sync = vs; i_de = de;
    e = '{default: 0};
    e.hs = hs; e.vs = vs; e.de = de;
    if (de) begin
      e.r = m_row; e.c = m_col;
      if (m_row < 64 && m_col < 32) img[m_row][m_col] = y;
      if (m_row >= 2 && m_col >= 2 && m_col < H) begin
        sum = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            wt = (i == 1 ? 2 : 1) * (j == 1 ? 2 : 1);
            sum += wt * img[m_row-2+i][m_col-2+j];
          end
        e.y = sum / 16;
      end
      m_col++;
    end else begin
      m_col = 0;
    end
    if (!vs) m_row = 0;
    else if (m_prev_de && !de && m_row < 4095) m_row++;
    m_prev_de = de;
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge pixel_clk);
    #2;
    reset_n = 1'b0;
    i_y = '0; i_h_sync = 1'b0; i_v_sync = 1'b0; i_de = 1'b0;
    #1;
    chk("rst_o_y", o_y, 0);
    chk("rst_o_h_sync", o_h_sync, 0);
    chk("rst_o_v_sync", o_v_sync, 0);
    chk("rst_o_de", o_de, 0);
    repeat (3) @(negedge pixel_clk);
    reset_n = 1'b1;
    m_row = 0; m_col = 0; m_prev_de = 1'b0;
    prefill();
  endtask

  function automatic int pix(input int kind, input int val, input int r, input int c);
    case (kind)
      0:       return val;
      1:       return (r == 10 && c == 10) ? val : 0;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic send_frame(input int w, input int h, input int kind, input int val, input int abort_row);
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < w + 4; k++) step(0, k < 2, 1'b0, 1'b0);
    for (int r = 0; r < h; r++) begin
      for (int k = 0; k < 4; k++) step(0, k < 2, 1'b1, 1'b0);
      for (int c = 0; c < w; c++) begin
        if (r == abort_row && c == 5) begin
          do_reset();
          return;
        end
        step(pix(kind, val, r, c), 1'b0, 1'b1, 1'b1);
      end
    end
    for (int k = 0; k < 4; k++) step(0, k < 2, 1'b1, 1'b0);
  endtask

  initial begin
    bit vs_r, de_r;
    prefill();
    repeat (2) @(negedge pixel_clk);
    #1;
    chk("reset_o_y", o_y, 0);
    chk("reset_o_de", o_de, 0);
    chk("reset_o_h_sync", o_h_sync, 0);
    chk("reset_o_v_sync", o_v_sync, 0);
    @(negedge pixel_clk);
    reset_n = 1'b1;

    // Random sync/de toggling with row pinned low: exercises the 3-cycle alignment.
    for (int n = 0; n < 200; n++) begin
      vs_r = 1'($urandom_range(0, 1));
      de_r = vs_r ? 1'b0 : 1'($urandom_range(0, 1));
      step(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), vs_r, de_r);
    end

    send_frame(16, 12, 0, 100, -1);
    chk("flat_centre", obs_img[5][5], 100);
    chk("flat_row1", obs_img[1][5], 0);
    chk("flat_col1", obs_img[5][1], 0);

    send_frame(16, 14, 1, 160, -1);
    chk("imp_11_11", obs_img[11][11], 40);
    chk("imp_11_10", obs_img[11][10], 20);
    chk("imp_11_12", obs_img[11][12], 20);
    chk("imp_10_11", obs_img[10][11], 20);
    chk("imp_12_11", obs_img[12][11], 20);
    chk("imp_10_10", obs_img[10][10], 10);
    chk("imp_12_12", obs_img[12][12], 10);
    chk("imp_far", obs_img[5][5], 0);

    send_frame(16, 14, 1, 1, -1);
    chk("trunc_one", obs_img[11][11], 0);

    send_frame(16, 6, 0, 255, -1);
    chk("trunc_255", obs_img[4][8], 255);

    send_frame(18, 6, 0, 50, -1);
    chk("ovl_col16", obs_img[3][16], 0);
    chk("ovl_col17", obs_img[3][17], 0);
    chk("ovl_col15", obs_img[3][15], 50);
    chk("ovl_col2", obs_img[3][2], 50);

    send_frame(16, 10, 2, 0, -1);
    send_frame(12, 8, 2, 0, -1);

    send_frame(16, 12, 0, 100, 8);
    send_frame(16, 12, 0, 100, -1);
    chk("post_rst_flat", obs_img[6][6], 100);
    chk("post_rst_row0", obs_img[0][6], 0);

    repeat (4) step(0, 1'b0, 1'b1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/y_gauss_3x3.md
Name: y_gauss_3x3

Overview:
Streaming 3x3 Gaussian smoothing stage on the luma channel. It sits directly downstream of rgb_to_ycbcr and consumes its o_y_8b, o_h_sync, o_v_sync and o_data_en. It emits the filtered Y with hs/vs/de delayed to stay aligned, for imwrite or later stages such as thresholding or edge detection. Two on-chip line buffers plus a 3x3 window register array form the neighbourhood.

Parameters:
H_ACTIVE, 800, max active pixels per line; sets line-buffer depth and column-counter range
DW, 8, pixel data width
SYNC_POL, 0, active level of i_v_sync (0 = active-low); hs is passed through untouched

Ports:
pixel_clk  input  1  pixel clock; all logic on rising edge
reset_n  input  1  asynchronous active-low reset
i_y  input  DW  luma in, valid when i_de=1
i_h_sync  input  1  horizontal sync in
i_v_sync  input  1  vertical sync in
i_de  input  1  data enable in
o_y  output  DW  filtered luma
o_h_sync  output  1  i_h_sync delayed 3 cycles
o_v_sync  output  1  i_v_sync delayed 3 cycles
o_de  output  1  i_de delayed 3 cycles

Behaviour:
- Clock and reset: one clock, pixel_clk. reset_n is asynchronous, active-low.
- Reset values: o_y=0, o_h_sync=0, o_v_sync=0, o_de=0. All counters, window registers and sync/de delay pipes clear to 0. Line-buffer RAM contents are not cleared.
- Latency: fixed 3 cycles for data, hs, vs and de. o_* at cycle t+3 corresponds to i_* at cycle t.
- col counter (clog2(H_ACTIVE) bits):
  - increments each cycle i_de=1; cleared on the cycle after i_de falls.
  - saturates at H_ACTIVE-1; pixels beyond that are "overflow".
- row counter (12 bits):
  - increments on each i_de falling edge (i_de_d=1, i_de=0).
  - held at 0 while i_v_sync==SYNC_POL.
  - saturates at 4095.
- Line buffers lb0 and lb1, each H_ACTIVE x DW, are written when i_de=1 and the pixel is not overflow:
  - lb0[col] <= i_y.
  - lb1[col] <= old lb0[col], read-before-write in the same cycle.
  - Taps are top = lb1[col] (row r-2), mid = lb0[col] (row r-1), bot = i_y (row r).
- Stage 1 (window): the 3x3 window shifts one column left when i_de=1 and holds otherwise. The incoming pixel is the bottom-right element. Stage 1 also registers the flag valid_win = (row>=2) && (col>=2) && !overflow.
- Stage 2 (partial sums): kernel [1 2 1; 2 4 2; 1 2 1].
  - Per-row weighted sums s_top = w00+2w01+w02, s_mid = 2(w10+2w11+w12), s_bot = w20+2w21+w22.
  - Registered, 12-bit unsigned; valid_win is pipelined alongside.
- Stage 3 (output):
  - sum = s_top + s_mid + s_bot, 12-bit; max 4080, no overflow.
  - o_y <= valid ? sum[11:4] : 0. Truncation (floor), no rounding.
  - o_y is also forced to 0 whenever the delayed de is 0.
- Geometric result: output at stream position (r,c) is the filtered value centred on input (r-1,c-1). Rows 0-1 and columns 0-1 of each frame output 0. The image is shifted one row down and one column right. This shift is intended.
- Boundary conditions:
  - Line shorter than H_ACTIVE: normal operation; unused buffer entries are ignored.
  - Line longer than H_ACTIVE: overflow pixels are not written and output 0.
  - de gap mid-line (de drops then rises): treated as a new line; row increments.
  - Simultaneous vs-active and de falling edge: the vs clear wins, so row=0.
  - Reset mid-frame: everything restarts at row 0 and col 0. Stale RAM is harmless because rows 0-1 output 0.
  - i_y is ignored when i_de=0.

Test Plan:
- Flat image: 800x600 frame, every Y=100 -> o_y=100 for all (r>=2,c>=2) with o_de=1; o_y=0 at rows 0-1 and cols 0-1.
- Impulse: Y=0 except input (10,10)=160 -> output at (11,11)=40, (11,10),(11,12),(10,11),(12,11)=20, diagonals (10,10),(10,12),(12,10),(12,12)=10, all others 0.
- Latency/alignment: toggle i_h_sync, i_v_sync and i_de at a known cycle -> o_h_sync, o_v_sync and o_de toggle exactly 3 cycles later. o_y=0 wherever o_de=0.
- Truncation: 3x3 neighbourhood all 255 -> 255. Centre 1, others 0 -> sum=4, output 0.
- Overlong line: H_ACTIVE=8, drive a 10-pixel line of Y=50 on rows >=2 -> pixels 8-9 output 0, pixels 2-7 output 50.
- Reset mid-frame: assert reset_n=0 at row 300 -> outputs 0 immediately (asynchronous). After release, the next frame's rows 0-1 output 0 and the rest match the flat-image scenario.
